pipeline_stall_controller: RTL



---
 rtl/pipeline_stall_controller_pkg.sv | 30 +++
 rtl/pipeline_stall_controller_sat_counter.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// default parameters and the bundle of pipeline-register control strobes.
package pipeline_stall_controller_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;
    localparam int unsigned CNT_W_DEFAULT       = 16;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
        logic memwb_bubble;
    } pipe_ctrl_t;

    // Pipeline frozen behind the memory stage (memory wait and HALT).
    function automatic pipe_ctrl_t ctrl_hold();
        pipe_ctrl_t c;
        c              = '0;
        c.pipe_hold    = 1'b1;
        c.memwb_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module pipeline_stall_controller_sat_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges load-use, taken-branch and memory
// handshake into pipeline-register enables, with memory timeout and stall count.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             mem_timeout_q;
    logic             mem_timeout_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_wait;
    logic             timeout_hit;
    logic             stall_inc;
    pipe_ctrl_t       ctrl;

    assign mem_wait    = mem_req && !mem_ready;
    // This wait cycle is the MEM_TIMEOUT-th consecutive one.
    assign timeout_hit = (wait_cnt >= TIMEOUT_M1);

    always_comb begin
        state_d       = state_q;
        mem_timeout_d = mem_timeout_q;
        ctrl          = '0;
        if (reset) begin
            ctrl.ifid_flush   = 1'b1;
            ctrl.idex_bubble  = 1'b1;
            ctrl.memwb_bubble = 1'b1;
            state_d           = ST_RUN;
            mem_timeout_d     = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.ifid_write = 1'b1;
                    if (mem_wait) begin
                        ctrl = ctrl_hold();
                        if (timeout_hit) begin
                            state_d       = ST_HALT;
                            mem_timeout_d = 1'b1;
                        end else begin
                            state_d = ST_MEM_WAIT;
                        end
                    end else begin
                        state_d = ST_RUN;
                        if (branch_taken) begin
                            ctrl.ifid_flush  = 1'b1;
                            ctrl.idex_bubble = 1'b1;
                        end else if (hazard_stall) begin
                            ctrl.pc_write    = 1'b0;
                            ctrl.ifid_write  = 1'b0;
                            ctrl.idex_bubble = 1'b1;
                        end
                    end
                end
                default: begin
                    ctrl    = ctrl_hold();
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        mem_timeout_q <= mem_timeout_d;
    end

    // Stalls are only counted while the pipeline is live.
    assign stall_inc = !reset && !ctrl.pc_write
                       && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT));

    pipeline_stall_controller_sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk     (clk),
        .clr_i   (reset || !mem_wait),
        .inc_i   (mem_wait),
        .count_o (wait_cnt)
    );

    pipeline_stall_controller_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (stall_inc),
        .count_o (stall_count)
    );

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign pipe_hold    = ctrl.pipe_hold;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign mem_timeout  = mem_timeout_q;

endmodule
